// File: rtl/add_mul_comp_pkg.sv
// Shared types and constants for the add/multiply/compare block.
package add_mul_comp_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Per-transaction operation select
    localparam logic [1:0] MODE_CMP_SEL = 2'b00;
    localparam logic [1:0] MODE_ADD     = 2'b01;
    localparam logic [1:0] MODE_MUL     = 2'b10;
    localparam logic [1:0] MODE_CMP     = 2'b11;

    // True when the transaction is resolved by the iterative multiplier
    function automatic logic is_mul_op(input logic [1:0] mode, input logic a_gt_b);
        return (mode == MODE_MUL) || ((mode == MODE_CMP_SEL) && a_gt_b);
    endfunction

endpackage

// File: rtl/amc_shift_add_core.sv
// Iterative shift-add multiplier datapath: one multiplier bit per step.
module amc_shift_add_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      count_q;

    // Accumulator value after the current step; also the final product on the last step
    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign done     = step && (count_q == CW'(WIDTH - 1));

    // Operand/accumulator registers: load on start, shift on each step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else if (load) begin
            mcand_q  <= {{WIDTH{1'b0}}, mcand_in};
            acc_q    <= '0;
            mplier_q <= mplier_in;
            count_q  <= '0;
        end else if (step) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/add_mul_comp_seq.sv
// Handshaked add / multiply / compare block with an iterative multiplier.
module add_mul_comp_seq
    import add_mul_comp_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 op_mul
);

    state_e state_q, state_d;

    logic [2*WIDTH-1:0] result_q, result_d;
    logic               op_mul_q, op_mul_d;

    logic               accept;
    logic               a_gt_b;
    logic               a_eq_b;
    logic               start_mul;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;
    logic               core_done;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign op_mul    = op_mul_q;

    assign accept    = in_valid && in_ready;
    assign a_gt_b    = (a > b);
    assign a_eq_b    = (a == b);
    assign start_mul = accept && is_mul_op(mode, a_gt_b);
    assign sum       = {1'b0, a} + {1'b0, b};

    amc_shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start_mul),
        .step      (state_q == MUL),
        .mcand_in  (a),
        .mplier_in (b),
        .acc_next  (acc_next),
        .done      (core_done)
    );

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = start_mul ? MUL : DONE;
            MUL:  if (core_done) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result capture: add/compare at accept, product on the last multiply step
    always_comb begin
        result_d = result_q;
        op_mul_d = op_mul_q;
        if (accept && !start_mul) begin
            op_mul_d = 1'b0;
            if (mode == MODE_CMP) begin
                result_d = {{(2*WIDTH-2){1'b0}}, a_gt_b, a_eq_b};
            end else begin
                result_d = {{(WIDTH-1){1'b0}}, sum};
            end
        end else if (core_done) begin
            result_d = acc_next;
            op_mul_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            op_mul_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            op_mul_q <= op_mul_d;
        end
    end

endmodule
